// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and types for the systolic array sequencer
package systolic_pkg;
  localparam int N = 4;
  localparam int W = 8;
  localparam int FEED_CYCLES = 2 * N - 1;
  localparam int DRAIN_CYCLES = N - 1;
  localparam int STEP_W = $clog2(3 * N - 2);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE} seq_state_t;
  typedef logic [N*N*W-1:0] mat_t;
endpackage

// File: rtl/skew_lane.sv
// skew_lane: selects element t-idx of an operand vector while feeding, else 0
module skew_lane #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = 4
) (
  input  logic [N*W-1:0] vec,
  input  logic [SW-1:0]  idx,
  input  logic [SW-1:0]  t,
  input  logic           en,
  output logic [W-1:0]   elem
);
  localparam int IW = $clog2(N);
  logic [SW:0] d;
  // lane delay by idx; negative or past-end offsets feed zero
  always_comb begin
    d = {1'b0, t} - {1'b0, idx};
    elem = (en && !d[SW] && d < (SW+1)'(N)) ? vec[W*d[IW-1:0] +: W] : '0;
  end
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: control FSM and skewed edge feed for an NxN systolic multiply array
module systolic_sequencer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N*N*W-1:0] matrix_a,
  input  logic [N*N*W-1:0] matrix_b,
  output logic [N*W-1:0]   a_edge,
  output logic [N*W-1:0]   b_edge,
  output logic             elem_clear,
  input  logic [N*N*W-1:0] array_c,
  output logic [N*N*W-1:0] result,
  output logic             busy,
  output logic             complete
);
  import systolic_pkg::*;
  localparam int SW = $clog2(3 * N - 2);
  localparam logic [SW-1:0] FEED_LAST = SW'(2 * N - 2);
  localparam logic [SW-1:0] DRAIN_LAST = SW'(3 * N - 3);
  seq_state_t state;
  logic [SW-1:0] t;
  logic [N*N*W-1:0] a_reg, b_reg;
  logic feed;
  assign feed = state == FEED;
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N*W-1:0] col;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign col[k*W +: W] = b_reg[(k*N+i)*W +: W];
    end
    skew_lane #(.N(N), .W(W), .SW(SW)) u_a (
      .vec(a_reg[i*N*W +: N*W]), .idx(SW'(i)), .t(t), .en(feed), .elem(a_edge[i*W +: W])
    );
    skew_lane #(.N(N), .W(W), .SW(SW)) u_b (
      .vec(col), .idx(SW'(i)), .t(t), .en(feed), .elem(b_edge[i*W +: W])
    );
  end
  // run sequencing with outputs registered alongside the state they belong to
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      t <= '0;
      a_reg <= '0;
      b_reg <= '0;
      result <= '0;
      elem_clear <= 1'b0;
      busy <= 1'b0;
      complete <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= CLEAR;
          t <= '0;
          a_reg <= matrix_a;
          b_reg <= matrix_b;
          elem_clear <= 1'b1;
          busy <= 1'b1;
          complete <= 1'b0;
        end
        CLEAR: begin
          state <= FEED;
          t <= '0;
          elem_clear <= 1'b0;
        end
        FEED: begin
          t <= t + 1'b1;
          if (t == FEED_LAST) state <= DRAIN;
        end
        DRAIN: begin
          t <= t + 1'b1;
          if (t == DRAIN_LAST) state <= CAPTURE;
        end
        CAPTURE: begin
          state <= DONE;
          result <= array_c;
          busy <= 1'b0;
          complete <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
